// File: rtl/intfmux_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : intfmux_gen_pkg
//  Description : Shared types and helpers for the time-slot mux/demux family.
//  Revision    : 1.0  initial release
// ============================================================================
package intfmux_gen_pkg;

  // Frame sequencer states, one bit wide
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Map transmit order k to the physical slice index inside the parallel word.
  // MSB-first sends the top slice as k=0; LSB-first sends the bottom slice.
  function automatic int slice_index(input int k, input int nslices, input bit lsb_first);
    return lsb_first ? k : (nslices - 1 - k);
  endfunction

endpackage
`default_nettype wire

// File: rtl/intfmux_edgedet.sv
`default_nettype none
// ============================================================================
//  Module      : intfmux_edgedet
//  Description : Samples the slow iclk in the synclk domain and flags one
//                rising edge after iclk has been seen high on two samples.
//  Revision    : 1.0  initial release
// ============================================================================
module intfmux_edgedet (
  input  logic rst_,
  input  logic synclk,
  input  logic iclk,
  output logic posdet
);

  logic [2:0] shfdet_q;

  // Shift iclk into the sampling chain; oldest sample sits in bit 2
  always_ff @(posedge synclk or negedge rst_) begin
    if (!rst_) shfdet_q <= 3'b000;
    else       shfdet_q <= {shfdet_q[1:0], iclk};
  end

  // Low then two consecutive highs: rejects pulses shorter than two samples
  assign posdet = (shfdet_q == 3'b011);

endmodule
`default_nettype wire

// File: rtl/intfmux_gen.sv
`default_nettype none
// ============================================================================
//  Module      : intfmux_gen
//  Description : Parallel-to-serial time-slot multiplexer. Latches a MUX-slice
//                word on each iclk rising edge and replays it as LINEBIT-wide
//                slices, each held for MAXTS synclk cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module intfmux_gen
  import intfmux_gen_pkg::*;
#(
  parameter int                 LINEBIT  = 1,
  parameter int                 MUX      = 4,
  parameter int                 PHBIT    = 4,
  parameter int                 MAXTS    = 6,
  parameter int                 BITTS    = 3,
  parameter bit                 LSBFIRST = 1'b0,
  parameter bit                 IDLEHOLD = 1'b1,
  parameter logic [LINEBIT-1:0] IDLEVAL  = '0,
  localparam int                DATABIT  = LINEBIT * MUX
) (
  input  logic               rst_,
  input  logic               synclk,
  input  logic               iclk,
  input  logic [DATABIT-1:0] idat,
  input  logic               en,
  input  logic               ovrclr,
  output logic [LINEBIT-1:0] odat,
  output logic               osyn,
  output logic               oval,
  output logic [PHBIT-1:0]   ophase,
  output logic               ovrerr
);

  localparam logic [BITTS-1:0]   LAST_TS  = BITTS'(MAXTS - 1);
  localparam logic [PHBIT-1:0]   LAST_PH  = PHBIT'(MUX - 1);
  localparam logic [LINEBIT-1:0] RST_ODAT = IDLEHOLD ? '0 : IDLEVAL;

  state_e               state_q,  state_d;
  logic [BITTS-1:0]     cntts_q,  cntts_d;
  logic [PHBIT-1:0]     cntph_q,  cntph_d;
  logic [DATABIT-1:0]   dreg_q,   dreg_d;
  logic [LINEBIT-1:0]   odat_q,   odat_d;
  logic                 osyn_q,   osyn_d;
  logic                 oval_q,   oval_d;
  logic                 ovrerr_q, ovrerr_d;

  logic posdet;
  logic capture;
  logic endts;
  logic lastcyc;

  // Pick transmit-order slice k out of a full parallel word
  function automatic logic [LINEBIT-1:0] slice_of(input logic [DATABIT-1:0] w,
                                                  input logic [PHBIT-1:0]   k);
    int idx;
    idx = slice_index(int'(k), MUX, LSBFIRST);
    return w[idx*LINEBIT +: LINEBIT];
  endfunction

  intfmux_edgedet u_edgedet (
    .rst_   (rst_),
    .synclk (synclk),
    .iclk   (iclk),
    .posdet (posdet)
  );

  assign capture = posdet & en;
  assign endts   = (state_q == ST_SEND) && (cntts_q == LAST_TS);
  // A capture here is a seamless back-to-back start rather than an overrun
  assign lastcyc = endts && (cntph_q == LAST_PH);

  // State and datapath registers
  always_ff @(posedge synclk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= ST_IDLE;
      cntts_q  <= '0;
      cntph_q  <= '0;
      dreg_q   <= '0;
      odat_q   <= RST_ODAT;
      osyn_q   <= 1'b0;
      oval_q   <= 1'b0;
      ovrerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cntts_q  <= cntts_d;
      cntph_q  <= cntph_d;
      dreg_q   <= dreg_d;
      odat_q   <= odat_d;
      osyn_q   <= osyn_d;
      oval_q   <= oval_d;
      ovrerr_q <= ovrerr_d;
    end
  end

  // Next-state: capture restarts the frame, otherwise step slot/phase counters
  always_comb begin
    state_d  = state_q;
    cntts_d  = cntts_q;
    cntph_d  = cntph_q;
    dreg_d   = dreg_q;
    odat_d   = odat_q;
    osyn_d   = osyn_q;
    oval_d   = oval_q;
    ovrerr_d = ovrerr_q;

    // Clear first so a simultaneous overrun still sets the flag
    if (ovrclr) ovrerr_d = 1'b0;
    if (capture && (state_q == ST_SEND) && !lastcyc) ovrerr_d = 1'b1;

    if (capture) begin
      // Slice 0 comes straight from the live word; later slices from dreg
      dreg_d  = idat;
      odat_d  = slice_of(idat, '0);
      osyn_d  = 1'b1;
      oval_d  = 1'b1;
      cntts_d = '0;
      cntph_d = '0;
      state_d = ST_SEND;
    end else if (state_q == ST_SEND) begin
      if (endts) begin
        cntts_d = '0;
        osyn_d  = 1'b0;
        if (cntph_q != LAST_PH) begin
          cntph_d = cntph_q + 1'b1;
          odat_d  = slice_of(dreg_q, cntph_q + 1'b1);
        end else begin
          cntph_d = '0;
          oval_d  = 1'b0;
          state_d = ST_IDLE;
          if (!IDLEHOLD) odat_d = IDLEVAL;
        end
      end else begin
        cntts_d = cntts_q + 1'b1;
      end
    end
  end

  assign odat   = odat_q;
  assign osyn   = osyn_q;
  assign oval   = oval_q;
  assign ophase = cntph_q;
  assign ovrerr = ovrerr_q;

endmodule
`default_nettype wire

// File: tb/tb_intfmux_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intfmux_gen
//  Description : Directed bench for intfmux_gen: MSB-first, LSB-first and
//                idle-fill instances share one stimulus stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_intfmux_gen;

  logic       rst_;
  logic       synclk;
  logic       iclk;
  logic [7:0] idat;
  logic       en;
  logic       ovrclr;

  logic [1:0] odat_m, odat_l, odat_i;
  logic       osyn_m, osyn_l, osyn_i;
  logic       oval_m, oval_l, oval_i;
  logic [3:0] ph_m, ph_l, ph_i;
  logic       err_m, err_l, err_i;

  int checks   = 0;
  int failures = 0;

  intfmux_gen #(.LINEBIT(2), .MUX(4), .PHBIT(4), .MAXTS(6), .BITTS(3),
                .LSBFIRST(1'b0), .IDLEHOLD(1'b1), .IDLEVAL(2'b00)) dut (
    .rst_(rst_), .synclk(synclk), .iclk(iclk), .idat(idat), .en(en), .ovrclr(ovrclr),
    .odat(odat_m), .osyn(osyn_m), .oval(oval_m), .ophase(ph_m), .ovrerr(err_m));

  intfmux_gen #(.LINEBIT(2), .MUX(4), .PHBIT(4), .MAXTS(6), .BITTS(3),
                .LSBFIRST(1'b1), .IDLEHOLD(1'b1), .IDLEVAL(2'b00)) dut_lsb (
    .rst_(rst_), .synclk(synclk), .iclk(iclk), .idat(idat), .en(en), .ovrclr(ovrclr),
    .odat(odat_l), .osyn(osyn_l), .oval(oval_l), .ophase(ph_l), .ovrerr(err_l));

  intfmux_gen #(.LINEBIT(2), .MUX(4), .PHBIT(4), .MAXTS(6), .BITTS(3),
                .LSBFIRST(1'b0), .IDLEHOLD(1'b0), .IDLEVAL(2'b11)) dut_idl (
    .rst_(rst_), .synclk(synclk), .iclk(iclk), .idat(idat), .en(en), .ovrclr(ovrclr),
    .odat(odat_i), .osyn(osyn_i), .oval(oval_i), .ophase(ph_i), .ovrerr(err_i));

  initial synclk = 1'b0;
  always #5 synclk = ~synclk;

  typedef struct {
    int         cyc;
    logic [1:0] od_m;
    logic [1:0] od_l;
    logic [1:0] od_i;
    logic       syn;
    logic       val;
    logic [3:0] ph;
    logic       err;
  } vec_t;

  localparam int NV = 11;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input int v);
    chk($sformatf("c%0d odat_msb", vec[v].cyc), 32'(odat_m), 32'(vec[v].od_m));
    chk($sformatf("c%0d odat_lsb", vec[v].cyc), 32'(odat_l), 32'(vec[v].od_l));
    chk($sformatf("c%0d odat_idl", vec[v].cyc), 32'(odat_i), 32'(vec[v].od_i));
    chk($sformatf("c%0d osyn", vec[v].cyc), 32'(osyn_m), 32'(vec[v].syn));
    chk($sformatf("c%0d oval", vec[v].cyc), 32'(oval_m), 32'(vec[v].val));
    chk($sformatf("c%0d ophase", vec[v].cyc), 32'(ph_m), 32'(vec[v].ph));
    chk($sformatf("c%0d ovrerr", vec[v].cyc), 32'(err_m), 32'(vec[v].err));
    chk($sformatf("c%0d ctl_lsb", vec[v].cyc), {24'd0, osyn_l, oval_l, ph_l, err_l},
        {24'd0, vec[v].syn, vec[v].val, vec[v].ph, vec[v].err});
    chk($sformatf("c%0d ctl_idl", vec[v].cyc), {24'd0, osyn_i, oval_i, ph_i, err_i},
        {24'd0, vec[v].syn, vec[v].val, vec[v].ph, vec[v].err});
  endtask

  task automatic nxt(input int n);
    for (int i = 0; i < n; i++) @(negedge synclk);
  endtask

  // Raise iclk on a negedge; two negedges later capture is asserted (frame c0)
  task automatic start_frame(input logic [7:0] w);
    idat = w;
    iclk = 1'b1;
    nxt(2);
  endtask

  initial begin
    // B4 = 10_11_01_00; MSB-first 10,11,01,00; LSB-first 00,01,11,10
    vec[0]  = '{0,  2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0};
    vec[1]  = '{1,  2'b10, 2'b00, 2'b10, 1'b1, 1'b1, 4'd0, 1'b0};
    vec[2]  = '{6,  2'b10, 2'b00, 2'b10, 1'b1, 1'b1, 4'd0, 1'b0};
    vec[3]  = '{7,  2'b11, 2'b01, 2'b11, 1'b0, 1'b1, 4'd1, 1'b0};
    vec[4]  = '{12, 2'b11, 2'b01, 2'b11, 1'b0, 1'b1, 4'd1, 1'b0};
    vec[5]  = '{13, 2'b01, 2'b11, 2'b01, 1'b0, 1'b1, 4'd2, 1'b0};
    vec[6]  = '{18, 2'b01, 2'b11, 2'b01, 1'b0, 1'b1, 4'd2, 1'b0};
    vec[7]  = '{19, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 4'd3, 1'b0};
    vec[8]  = '{24, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 4'd3, 1'b0};
    vec[9]  = '{25, 2'b00, 2'b10, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0};
    vec[10] = '{30, 2'b00, 2'b10, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0};

    rst_ = 1'b0; iclk = 1'b0; idat = 8'h00; en = 1'b1; ovrclr = 1'b0;
    nxt(2);
    chk("reset odat_msb", 32'(odat_m), 32'd0);
    chk("reset odat_idl", 32'(odat_i), 32'h3);
    chk("reset ctl", {28'd0, osyn_m, oval_m, err_m, |ph_m}, 32'd0);
    rst_ = 1'b1;
    nxt(3);

    // Frame 1: table-driven, idat zeroed one cycle after capture
    start_frame(8'hB4);
    for (int c = 0; c <= 30; c++) begin
      if (c > 0) nxt(1);
      if (c == 1) idat = 8'h00;
      if (c == 3) iclk = 1'b0;
      for (int v = 0; v < NV; v++)
        if (vec[v].cyc == c) check_vec(v);
    end

    // Overrun, ovrclr, ovrclr-vs-overrun, then reset mid-frame
    start_frame(8'hB4);
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) nxt(1);
      case (c)
        3:  iclk = 1'b0;
        8:  begin iclk = 1'b1; idat = 8'h1B; end
        10: begin
              chk("ovr pre odat", 32'(odat_m), 32'h3);
              chk("ovr pre phase", 32'(ph_m), 32'd1);
              chk("ovr pre err", 32'(err_m), 32'd0);
            end
        11: begin
              chk("ovr odat_msb", 32'(odat_m), 32'h0);
              chk("ovr odat_lsb", 32'(odat_l), 32'h3);
              chk("ovr syn/val/ph", {28'd0, osyn_m, oval_m, ph_m[1:0]}, 32'b1100);
              chk("ovr err set", 32'(err_m), 32'd1);
              iclk = 1'b0;
            end
        12: ovrclr = 1'b1;
        13: begin ovrclr = 1'b0; chk("ovrclr clears", 32'(err_m), 32'd0); end
        14: begin iclk = 1'b1; idat = 8'hB4; end
        16: ovrclr = 1'b1;
        17: begin
              ovrclr = 1'b0;
              chk("set beats clr", 32'(err_m), 32'd1);
              chk("restart odat", 32'(odat_m), 32'h2);
              chk("restart syn/ph", {28'd0, osyn_m, ph_m[2:0]}, 32'b1000);
            end
        20: iclk = 1'b0;
        24: begin
              chk("pre-rst phase", 32'(ph_m), 32'd1);
              chk("pre-rst odat", 32'(odat_m), 32'h3);
              rst_ = 1'b0;
              #1;
              chk("rst odat_msb", 32'(odat_m), 32'd0);
              chk("rst odat_lsb", 32'(odat_l), 32'd0);
              chk("rst odat_idl", 32'(odat_i), 32'h3);
              chk("rst ctl", {27'd0, osyn_m, oval_m, err_m, ph_m[1:0]}, 32'd0);
            end
        default: ;
      endcase
    end
    nxt(2);
    rst_ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt(1);
      chk("post-rst idle", {28'd0, oval_m, osyn_m, ph_m[1:0]}, 32'd0);
    end

    // Back-to-back: capture on final frame cycle 24
    start_frame(8'hB4);
    for (int c = 0; c <= 31; c++) begin
      if (c > 0) nxt(1);
      if (c == 3) iclk = 1'b0;
      if (c == 22) begin iclk = 1'b1; idat = 8'h4E; end
      if (c == 26) iclk = 1'b0;
      if (c >= 1) chk($sformatf("b2b oval c%0d", c), 32'(oval_m), 32'd1);
      if (c == 24) chk("b2b last", {28'd0, osyn_m, ph_m[2:0]}, 32'b0011);
      if (c == 25) begin
        chk("b2b syn/ph", {28'd0, osyn_m, ph_m[2:0]}, 32'b1000);
        chk("b2b odat_msb", 32'(odat_m), 32'h1);
        chk("b2b odat_lsb", 32'(odat_l), 32'h2);
        chk("b2b err", 32'(err_m), 32'd0);
      end
      if (c == 30) chk("b2b syn held", 32'(osyn_m), 32'd1);
      if (c == 31) begin
        chk("b2b slice1", {28'd0, osyn_m, ph_m[1:0], 1'b0}, 32'b0010);
        chk("b2b odat s1", 32'(odat_m), 32'h0);
      end
    end
    nxt(30);

    // en low: iclk edge must not start a frame
    en = 1'b0;
    iclk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      nxt(1);
      chk("en=0 no frame", {30'd0, oval_m, oval_i}, 32'd0);
    end
    iclk = 1'b0;
    nxt(3);
    en = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
